// File: rtl/i2c_target.sv
// I2C target engine: oversamples SCL/SDA, detects START/STOP, matches a 7-bit address,
// receives bytes to rx_data with ACK and shifts tx_data onto SDA for controller reads.
module i2c_target #(
    parameter logic [6:0] ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic       rw,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_RX,
        S_RX_ACK,
        S_TX,
        S_TX_ACK
    } state_t;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [6:0] shift_reg;
    logic [6:0] tx_shift;
    logic       ack_phase;

    logic scl_meta, scl_sync, scl_dly;
    logic sda_meta, sda_sync, sda_dly;
    logic scl_rise, scl_fall, sda_rise, sda_fall;
    logic start_det, stop_det;

    // Synchronizers reset to the idle-high bus level so leaving reset creates no false edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_meta <= 1'b1;
            scl_sync <= 1'b1;
            scl_dly  <= 1'b1;
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
            sda_dly  <= 1'b1;
        end else begin
            scl_meta <= scl_in;
            scl_sync <= scl_meta;
            scl_dly  <= scl_sync;
            sda_meta <= sda_in;
            sda_sync <= sda_meta;
            sda_dly  <= sda_sync;
        end
    end

    assign scl_rise  = scl_sync & ~scl_dly;
    assign scl_fall  = ~scl_sync & scl_dly;
    assign sda_rise  = sda_sync & ~sda_dly;
    assign sda_fall  = ~sda_sync & sda_dly;
    assign start_det = sda_fall & scl_sync;
    assign stop_det  = sda_rise & scl_sync;

    // ack_phase marks the second half of an ACK slot: after the drive edge in ADDR_ACK/RX_ACK,
    // or after a controller ACK was sampled in TX_ACK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            bit_cnt   <= 3'd0;
            shift_reg <= 7'd0;
            tx_shift  <= 7'd0;
            ack_phase <= 1'b0;
            sda_oe    <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            tx_load   <= 1'b0;
            rw        <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_load  <= 1'b0;
            if (start_det) begin
                state     <= S_ADDR;
                bit_cnt   <= 3'd0;
                ack_phase <= 1'b0;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
            end else if (stop_det) begin
                state     <= S_IDLE;
                bit_cnt   <= 3'd0;
                ack_phase <= 1'b0;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                    end
                    S_ADDR: begin
                        if (scl_rise) begin
                            shift_reg <= {shift_reg[5:0], sda_sync};
                            bit_cnt   <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (shift_reg == ADDR) begin
                                    rw        <= sda_sync;
                                    ack_phase <= 1'b0;
                                    state     <= S_ADDR_ACK;
                                end else begin
                                    state <= S_IDLE;
                                end
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                sda_oe    <= 1'b1;
                                busy      <= 1'b1;
                                ack_phase <= 1'b1;
                            end else if (rw) begin
                                tx_load  <= 1'b1;
                                tx_shift <= tx_data[6:0];
                                sda_oe   <= ~tx_data[7];
                                bit_cnt  <= 3'd0;
                                state    <= S_TX;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= 3'd0;
                                state   <= S_RX;
                            end
                        end
                    end
                    S_RX: begin
                        if (scl_rise) begin
                            shift_reg <= {shift_reg[5:0], sda_sync};
                            bit_cnt   <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_data   <= {shift_reg, sda_sync};
                                rx_valid  <= 1'b1;
                                ack_phase <= 1'b0;
                                state     <= S_RX_ACK;
                            end
                        end
                    end
                    S_RX_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                sda_oe    <= 1'b1;
                                ack_phase <= 1'b1;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= 3'd0;
                                state   <= S_RX;
                            end
                        end
                    end
                    S_TX: begin
                        // Bit 7 went out on entry; each fall here advances one bit, the last one releases.
                        if (scl_fall) begin
                            if (bit_cnt == 3'd7) begin
                                sda_oe    <= 1'b0;
                                ack_phase <= 1'b0;
                                state     <= S_TX_ACK;
                            end else begin
                                sda_oe   <= ~tx_shift[6];
                                tx_shift <= {tx_shift[5:0], 1'b0};
                                bit_cnt  <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    S_TX_ACK: begin
                        if (scl_rise) begin
                            if (sda_sync) begin
                                sda_oe <= 1'b0;
                                busy   <= 1'b0;
                                state  <= S_IDLE;
                            end else begin
                                ack_phase <= 1'b1;
                            end
                        end else if (scl_fall && ack_phase) begin
                            tx_load  <= 1'b1;
                            tx_shift <= tx_data[6:0];
                            sda_oe   <= ~tx_data[7];
                            bit_cnt  <= 3'd0;
                            state    <= S_TX;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: a behavioural I2C controller drives randomized
// transfers on a wired-AND bus and checks ACKs, received/transmitted bytes and status flags.
module tb_i2c_target;

    localparam int Q = 8;
    localparam logic [6:0] TARGET = 7'h50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_ctl = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_load;
    logic       rw;
    logic       busy;

    int checks = 0;
    int errors = 0;

    assign sda_bus = sda_ctl & ~sda_oe;

    i2c_target #(.ADDR(TARGET)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_in   (scl),
        .sda_in   (sda_bus),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .rw       (rw),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse monitor: collects received bytes, counts tx_load and checks pulse shape and drive timing.
    logic [7:0] act_rx[$];
    int   txl_cnt = 0;
    logic prev_oe = 1'b0, prev_rxv = 1'b0, prev_txl = 1'b0;

    always @(negedge clk) begin
        if (rx_valid) begin
            act_rx.push_back(rx_data);
            checkOutput("rxv_width", {31'd0, prev_rxv}, 0);
            checkOutput("pulse_overlap", {31'd0, tx_load}, 0);
        end
        if (tx_load) begin
            txl_cnt++;
            checkOutput("txl_width", {31'd0, prev_txl}, 0);
        end
        if (sda_oe && !prev_oe)
            checkOutput("oe_rise_scl_high", {31'd0, scl}, 0);
        prev_oe  = sda_oe;
        prev_rxv = rx_valid;
        prev_txl = tx_load;
    end

    task automatic waitQ();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic busStart();
        waitQ(); sda_ctl = 1'b1;
        waitQ(); scl = 1'b1;
        waitQ(); sda_ctl = 1'b0;
        waitQ(); scl = 1'b0;
    endtask

    task automatic busStop();
        waitQ(); sda_ctl = 1'b0;
        waitQ(); scl = 1'b1;
        waitQ(); sda_ctl = 1'b1;
        waitQ();
    endtask

    task automatic busBit(input logic drv, output logic seen);
        waitQ(); sda_ctl = drv;
        waitQ(); scl = 1'b1;
        waitQ(); seen = sda_bus;
        waitQ(); scl = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, output logic [7:0] echo, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            busBit(b[i], s);
            echo = {echo[6:0], s};
        end
        busBit(1'b1, ack);
    endtask

    task automatic readByte(input logic nack, input logic [7:0] next_tx, output logic [7:0] b);
        logic s;
        for (int i = 0; i < 8; i++) begin
            busBit(1'b1, s);
            b = {b[6:0], s};
        end
        tx_data = next_tx;
        busBit(nack, s);
    endtask

    // Write model: only the matching address gets ACKs, and every data byte then appears on rx_data.
    task automatic applyStimulus(input logic [6:0] addr, input int n, input logic [7:0] first);
        logic [7:0] exp_rx[$];
        logic [7:0] data, echo;
        logic ack;
        bit   match;
        int   base;
        match = (addr == TARGET);
        base = act_rx.size();
        busStart();
        sendByte({addr, 1'b0}, echo, ack);
        checkOutput("wr_addr_echo", echo, {addr, 1'b0});
        checkOutput("wr_addr_ack", {31'd0, ack}, match ? 0 : 1);
        checkOutput("wr_busy", {31'd0, busy}, match ? 1 : 0);
        if (match) checkOutput("wr_rw", {31'd0, rw}, 0);
        for (int k = 0; k < n; k++) begin
            data = (k == 0) ? first : 8'($urandom);
            if (match) exp_rx.push_back(data);
            sendByte(data, echo, ack);
            checkOutput("wr_data_echo", echo, data);
            checkOutput("wr_data_ack", {31'd0, ack}, match ? 0 : 1);
        end
        busStop();
        checkOutput("wr_busy_stop", {31'd0, busy}, 0);
        checkOutput("wr_rx_count", act_rx.size() - base, exp_rx.size());
        for (int k = 0; k < exp_rx.size() && base + k < act_rx.size(); k++)
            checkOutput("wr_rx_data", act_rx[base + k], exp_rx[k]);
    endtask

    // Read model: the bus carries the supplied bytes in order, one tx_load each, NACK ends it.
    task automatic doRead(input int n, input logic [7:0] b0, input logic [7:0] b1);
        logic [7:0] bytes[$];
        logic [7:0] got, echo;
        logic ack;
        int   tbase, rbase;
        for (int k = 0; k < n; k++)
            bytes.push_back(k == 0 ? b0 : (k == 1 ? b1 : 8'($urandom)));
        bytes.push_back(8'($urandom));
        tbase = txl_cnt;
        rbase = act_rx.size();
        tx_data = bytes[0];
        busStart();
        sendByte({TARGET, 1'b1}, echo, ack);
        checkOutput("rd_addr_ack", {31'd0, ack}, 0);
        checkOutput("rd_rw", {31'd0, rw}, 1);
        checkOutput("rd_busy", {31'd0, busy}, 1);
        for (int k = 0; k < n; k++) begin
            readByte(k == n - 1, bytes[k + 1], got);
            checkOutput("rd_byte", got, bytes[k]);
        end
        waitQ();
        checkOutput("rd_nack_oe", {31'd0, sda_oe}, 0);
        checkOutput("rd_nack_busy", {31'd0, busy}, 0);
        checkOutput("rd_txload_count", txl_cnt - tbase, n);
        checkOutput("rd_no_rx", act_rx.size() - rbase, 0);
        busStop();
    endtask

    initial begin
        logic [7:0] echo, got, b;
        logic ack, s;
        int rbase, tbase;

        repeat (5) @(posedge clk);
        #1;
        checkOutput("rst_sda_oe", {31'd0, sda_oe}, 0);
        checkOutput("rst_rx_data", {24'd0, rx_data}, 0);
        checkOutput("rst_rx_valid", {31'd0, rx_valid}, 0);
        checkOutput("rst_tx_load", {31'd0, tx_load}, 0);
        checkOutput("rst_rw", {31'd0, rw}, 0);
        checkOutput("rst_busy", {31'd0, busy}, 0);
        rst_n = 1'b1;
        waitQ();

        applyStimulus(TARGET, 1, 8'hA5);
        applyStimulus(7'h51, 1, 8'hFF);
        applyStimulus(7'h00, 1, 8'h3C);
        for (int i = 0; i < 6; i++)
            applyStimulus(($urandom_range(0, 1) == 1) ? TARGET : 7'($urandom_range(81, 127)),
                          $urandom_range(1, 3), 8'($urandom));

        doRead(2, 8'h3C, 8'hC3);
        for (int i = 0; i < 4; i++)
            doRead($urandom_range(1, 3), 8'($urandom), 8'($urandom));

        // Repeated START after 4 bits of a write byte, then a read.
        rbase = act_rx.size();
        busStart();
        sendByte({TARGET, 1'b0}, echo, ack);
        checkOutput("rs_wr_ack", {31'd0, ack}, 0);
        for (int i = 0; i < 4; i++) busBit(1'($urandom), s);
        b = 8'($urandom);
        tx_data = b;
        tbase = txl_cnt;
        busStart();
        checkOutput("rs_busy_cleared", {31'd0, busy}, 0);
        sendByte({TARGET, 1'b1}, echo, ack);
        checkOutput("rs_rd_ack", {31'd0, ack}, 0);
        checkOutput("rs_rw", {31'd0, rw}, 1);
        readByte(1'b1, 8'($urandom), got);
        checkOutput("rs_byte", got, b);
        busStop();
        checkOutput("rs_no_rx", act_rx.size() - rbase, 0);
        checkOutput("rs_txload", txl_cnt - tbase, 1);

        // STOP after 5 bits of a read byte; bit 2 is 1 so SDA is free for the STOP.
        b = 8'($urandom) | 8'h04;
        tx_data = b;
        busStart();
        sendByte({TARGET, 1'b1}, echo, ack);
        checkOutput("sp_addr_ack", {31'd0, ack}, 0);
        got = 8'h00;
        for (int i = 0; i < 5; i++) begin
            busBit(1'b1, s);
            got = {got[6:0], s};
        end
        checkOutput("sp_partial", {27'd0, got[4:0]}, {27'd0, b[7:3]});
        checkOutput("sp_busy_before", {31'd0, busy}, 1);
        busStop();
        checkOutput("sp_oe", {31'd0, sda_oe}, 0);
        checkOutput("sp_busy", {31'd0, busy}, 0);
        sendByte({TARGET, 1'b0}, echo, ack);
        checkOutput("sp_idle_no_ack", {31'd0, ack}, 1);
        busStop();

        // Reset while the target holds the address ACK.
        busStart();
        for (int i = 7; i >= 0; i--) busBit(i == 0 ? 1'b0 : TARGET[i - 1], s);
        waitQ(); sda_ctl = 1'b1;
        waitQ(); scl = 1'b1;
        waitQ();
        checkOutput("rr_ack_oe", {31'd0, sda_oe}, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("rr_oe_reset", {31'd0, sda_oe}, 0);
        checkOutput("rr_busy_reset", {31'd0, busy}, 0);
        waitQ(); rst_n = 1'b1;
        waitQ(); scl = 1'b0;
        busStop();
        applyStimulus(TARGET, 1, 8'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
